regfile_wb_arbiter: RTL and testbench

Writeback controller for the 32x32 register file. Shares the register file's single write port (a3/wd3/we) between the ALU writeback path and the load-return path. Also keeps a scoreboard of registers with outstanding loads, so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file, and is the only driver of the register-file write port.

---
 rtl/regfile_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Sole driver of the 32x32 register file write port (a3/wd3/we). It
//   arbitrates between the ALU writeback path and the load-return path, and
//   keeps a busy scoreboard of registers with outstanding loads so that
//   decode can stall on RAW hazards.
//
//   Build option: REGFILE_ARB_STARVE_EN
//     defined   - a starvation counter forces the ALU to win a conflict after
//                 STARVE_LIMIT consecutive lost cycles.
//     undefined - the load always wins a conflict.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_alu_valid/rd/data     ALU writeback request
//   o_alu_ready             ALU request accepted this cycle
//   i_ld_valid/rd/data      load-return writeback request
//   o_ld_ready              load request accepted this cycle
//   i_ld_issue, _rd         load issued this cycle, and its destination
//   i_rs1, i_rs2            decode source registers
//   o_hz1, o_hz2            source register has an outstanding load
//   o_sb_err                sticky: load issued to an already-busy register
//   o_a3, o_wd3, o_we       register file write port
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_issue_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_hz1,
  output logic        o_hz2,
  output logic        o_sb_err,
  output logic [4:0]  o_a3,
  output logic [31:0] o_wd3,
  output logic        o_we
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  logic        w_alu_prio;
  logic        w_alu_gnt;
  logic        w_ld_gnt;
  logic [31:0] r_busy;
  logic [31:0] w_busy_set;
  logic [31:0] w_busy_clr;
  logic [31:0] w_busy_nxt;
  logic        r_sb_err;
  logic [4:0]  r_a3;
  logic [31:0] r_wd3;
  logic        r_we;

`ifdef REGFILE_ARB_STARVE_EN
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_alu_prio = (r_starve_cnt == LP_LIMIT);

  // Counts consecutive cycles the ALU is waiting without a grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_alu_valid || w_alu_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_alu_prio = 1'b0;
`endif

  // Load wins a conflict unless the ALU has been starved long enough.
  // Nothing is granted while reset is asserted.
  always_comb begin
    w_ld_gnt  = 1'b0;
    w_alu_gnt = 1'b0;
    if (!i_reset) begin
      if (i_ld_valid && !(i_alu_valid && w_alu_prio)) begin
        w_ld_gnt = 1'b1;
      end else if (i_alu_valid) begin
        w_alu_gnt = 1'b1;
      end
    end
  end

  assign o_alu_ready = w_alu_gnt;
  assign o_ld_ready  = w_ld_gnt;

  // Write port stage; a3/wd3 hold when idle, x0 writes are suppressed via we.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we  <= 1'b0;
      r_a3  <= 5'd0;
      r_wd3 <= 32'd0;
    end else if (w_ld_gnt) begin
      r_we  <= (i_ld_rd != 5'd0);
      r_a3  <= i_ld_rd;
      r_wd3 <= i_ld_data;
    end else if (w_alu_gnt) begin
      r_we  <= (i_alu_rd != 5'd0);
      r_a3  <= i_alu_rd;
      r_wd3 <= i_alu_data;
    end else begin
      r_we  <= 1'b0;
    end
  end

  // Scoreboard: a set in the same cycle as a clear to that register wins.
  always_comb begin
    w_busy_set = 32'd0;
    w_busy_clr = 32'd0;
    if (i_ld_issue && (i_ld_issue_rd != 5'd0)) begin
      w_busy_set[i_ld_issue_rd] = 1'b1;
    end
    if (w_ld_gnt) begin
      w_busy_clr[i_ld_rd] = 1'b1;
    end
    w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy   <= 32'd0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (|(w_busy_set & r_busy)) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign o_hz1    = r_busy[i_rs1];
  assign o_hz2    = r_busy[i_rs2];
  assign o_sb_err = r_sb_err;
  assign o_a3     = r_a3;
  assign o_wd3    = r_wd3;
  assign o_we     = r_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled before the next rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs1, rs2;
  logic        hz1, hz2;
  logic        sb_err;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .o_alu_ready  (alu_ready),
    .i_ld_valid   (ld_valid),
    .i_ld_rd      (ld_rd),
    .i_ld_data    (ld_data),
    .o_ld_ready   (ld_ready),
    .i_ld_issue   (ld_issue),
    .i_ld_issue_rd(ld_issue_rd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_hz1        (hz1),
    .o_hz2        (hz2),
    .o_sb_err     (sb_err),
    .o_a3         (a3),
    .o_wd3        (wd3),
    .o_we         (we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_alu;
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h2;
    ld_issue = 1'b0; ld_issue_rd = 5'd0;
    rs1 = 5'd7; rs2 = 5'd3;

    // Reset with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
    end
    chk("rst_we", we, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_hz1", hz1, 0);
    chk("rst_hz2", hz2, 0);
    chk("rst_sb_err", sb_err, 0);
    reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h2A;
    #1;
    chk("alu_ready", alu_ready, 1);
    chk("alu_ld_ready", ld_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("alu_we", we, 1);
    chk("alu_a3", a3, 5);
    chk("alu_wd3", wd3, 32'h2A);
    tick();
    chk("idle_we", we, 0);
    chk("idle_a3_hold", a3, 5);
    chk("idle_wd3_hold", wd3, 32'h2A);

    // Conflict: load first, ALU next cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h22;
    #1;
    chk("cf_ld_ready", ld_ready, 1);
    chk("cf_alu_ready", alu_ready, 0);
    tick();
    ld_valid = 1'b0;
    chk("cf1_we", we, 1);
    chk("cf1_a3", a3, 4);
    chk("cf1_wd3", wd3, 32'h22);
    #1;
    chk("cf2_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("cf2_we", we, 1);
    chk("cf2_a3", a3, 3);
    chk("cf2_wd3", wd3, 32'h11);

    // Starvation: continuous load returns, ALU held
    ld_valid  = 1'b1; ld_rd  = 5'd9;  ld_data  = 32'h99;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
    for (int i = 1; i <= 6; i++) begin
      #1;
`ifdef REGFILE_ARB_STARVE_EN
      exp_alu = (i == 5);
`else
      exp_alu = 1'b0;
`endif
      chk($sformatf("starve_alu_ready_c%0d", i), alu_ready, exp_alu);
      chk($sformatf("starve_ld_ready_c%0d", i), ld_ready, !exp_alu);
      tick();
      if (exp_alu) begin
        alu_valid = 1'b0;
        chk("starve_alu_a3", a3, 10);
      end else begin
        chk($sformatf("starve_ld_a3_c%0d", i), a3, 9);
      end
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    tick();
    chk("starve_idle_we", we, 0);

    // x0 drop
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    #1;
    chk("x0_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    chk("x0_we", we, 0);
    chk("x0_hz1", hz1, 0);

    // Scoreboard set
    ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("sb_same_cycle_hz1", hz1, 0);
    tick();
    ld_issue = 1'b0;
    chk("sb_set_hz1", hz1, 1);
    chk("sb_set_hz2", hz2, 1);
    chk("sb_no_err", sb_err, 0);

    // Re-issue while busy
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    chk("sb_err_set", sb_err, 1);
    chk("sb_err_hz1", hz1, 1);

    // Return and new issue to the same register in one cycle
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    #1;
    chk("sb_both_ld_ready", ld_ready, 1);
    tick();
    ld_issue = 1'b0; ld_valid = 1'b0;
    chk("sb_set_wins_hz1", hz1, 1);
    chk("sb_both_we", we, 1);

    // Lone return clears
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
    tick();
    ld_valid = 1'b0;
    chk("sb_clr_hz1", hz1, 0);
    chk("sb_clr_a3", a3, 7);
    chk("sb_clr_wd3", wd3, 32'h78);
    chk("sb_err_sticky", sb_err, 1);

    // Reset mid-operation clears scoreboard and error
    ld_issue = 1'b1; ld_issue_rd = 5'd12; rs2 = 5'd12;
    tick();
    ld_issue = 1'b0;
    chk("mid_hz2_busy", hz2, 1);
    reset = 1'b1; ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hCC;
    #1;
    chk("mid_rst_ld_ready", ld_ready, 0);
    tick();
    reset = 1'b0; ld_valid = 1'b0;
    chk("mid_rst_hz2", hz2, 0);
    chk("mid_rst_sb_err", sb_err, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_a3", a3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
